// File: rtl/mode_register.sv
`default_nettype none
// ============================================================================
// Module      : mode_register
// Description : WIDTH-bit register with a small set of operations: hold,
//               parallel load, clear, increment, decrement, shift left,
//               shift right and rotate left. It also provides registered
//               zero and carry/borrow/shift-out flags. Each operation is
//               sampled on the rising clock edge and takes one cycle.
//
// Parameters  : WIDTH    data width in bits (2..64)
//               RST_VAL  value of out while in reset, truncated to WIDTH
//
// Ports       : clk    in   rising-edge clock
//               rstn   in   asynchronous active-low reset
//               en     in   operation enable; the register holds when low
//               op     in   [2:0] operation select:
//                             000 HOLD, 001 LOAD, 010 CLR, 011 INC,
//                             100 DEC, 101 SHL, 110 SHR, 111 ROL
//               wdata  in   [WIDTH-1:0] parallel load data
//               sin    in   serial input bit for SHL/SHR
//               out    out  [WIDTH-1:0] registered value
//               zero   out  registered flag, high when out is all-zeros
//               carry  out  registered carry / borrow / shift-out flag
//
// Build macro : MODE_REG_SAT_EN  when defined, INC and DEC saturate at
//               all-ones and zero instead of wrapping. Carry is still set
//               on the saturating step. No other operation is affected.
//
// Revision    : 1.0  initial release
// ============================================================================
module mode_register #(
  parameter int          WIDTH   = 8,
  parameter logic [63:0] RST_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] wdata,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] c_OP_HOLD = 3'b000;
  localparam logic [2:0] c_OP_LOAD = 3'b001;
  localparam logic [2:0] c_OP_CLR  = 3'b010;
  localparam logic [2:0] c_OP_INC  = 3'b011;
  localparam logic [2:0] c_OP_DEC  = 3'b100;
  localparam logic [2:0] c_OP_SHL  = 3'b101;
  localparam logic [2:0] c_OP_SHR  = 3'b110;
  localparam logic [2:0] c_OP_ROL  = 3'b111;

  localparam logic [WIDTH-1:0] c_RST_VAL = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_carry;

  logic [WIDTH-1:0] w_next_out;
  logic             w_next_carry;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_all_ones;
  logic             w_is_zero;

  assign w_inc      = r_out + c_ONE;
  assign w_dec      = r_out - c_ONE;
  assign w_all_ones = &r_out;
  assign w_is_zero  = ~|r_out;

  // Next-state decode. Carry depends only on the old value and the op,
  // never on sin.
  always_comb begin
    w_next_out   = r_out;
    w_next_carry = r_carry;
    if (en) begin
      case (op)
        c_OP_HOLD: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
        c_OP_LOAD: begin
          w_next_out   = wdata;
          w_next_carry = 1'b0;
        end
        c_OP_CLR: begin
          w_next_out   = '0;
          w_next_carry = 1'b0;
        end
        c_OP_INC: begin
`ifdef MODE_REG_SAT_EN
          w_next_out   = w_all_ones ? r_out : w_inc;
`else
          w_next_out   = w_inc;
`endif
          w_next_carry = w_all_ones;
        end
        c_OP_DEC: begin
`ifdef MODE_REG_SAT_EN
          w_next_out   = w_is_zero ? r_out : w_dec;
`else
          w_next_out   = w_dec;
`endif
          w_next_carry = w_is_zero;
        end
        c_OP_SHL: begin
          w_next_out   = {r_out[WIDTH-2:0], sin};
          w_next_carry = r_out[WIDTH-1];
        end
        c_OP_SHR: begin
          w_next_out   = {sin, r_out[WIDTH-1:1]};
          w_next_carry = r_out[0];
        end
        c_OP_ROL: begin
          w_next_out   = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
          w_next_carry = r_out[WIDTH-1];
        end
        default: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
      endcase
    end
  end

  // The zero flag is registered from the next value. This keeps it
  // cycle-aligned with out without adding a comparator on the output path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out   <= c_RST_VAL;
      r_carry <= 1'b0;
      r_zero  <= (c_RST_VAL == '0);
    end else begin
      r_out   <= w_next_out;
      r_carry <= w_next_carry;
      r_zero  <= (w_next_out == '0);
    end
  end

  assign out   = r_out;
  assign zero  = r_zero;
  assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_mode_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_register
// Description : Self-checking bench for mode_register. It drives three
//               instances from the same stimulus: WIDTH=8 with RST_VAL=0,
//               WIDTH=8 with RST_VAL=3C, and WIDTH=2. Results are checked
//               against an arithmetic reference model. The bench runs
//               directed sequences first, then randomized operations with
//               occasional asynchronous reset pulses. It follows the
//               MODE_REG_SAT_EN build macro.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mode_register;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [2:0] op;
  logic [7:0] wdata;
  logic       sin;

  logic [7:0] out_a, out_b;
  logic [1:0] out_c;
  logic       zero_a, zero_b, zero_c;
  logic       carry_a, carry_b, carry_c;

  mode_register #(.WIDTH(8), .RST_VAL(64'h0)) u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .op(op), .wdata(wdata), .sin(sin),
    .out(out_a), .zero(zero_a), .carry(carry_a));

  mode_register #(.WIDTH(8), .RST_VAL(64'h3C)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .op(op), .wdata(wdata), .sin(sin),
    .out(out_b), .zero(zero_b), .carry(carry_b));

  mode_register #(.WIDTH(2), .RST_VAL(64'h0)) u_dut_c (
    .clk(clk), .rstn(rstn), .en(en), .op(op), .wdata(wdata[1:0]), .sin(sin),
    .out(out_c), .zero(zero_c), .carry(carry_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model state, one per instance.
  logic [63:0] m_out_a, m_out_b, m_out_c;
  logic        m_car_a, m_car_b, m_car_c;

`ifdef MODE_REG_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Computes the next {carry, out} from the operation table using plain
  // arithmetic on a WIDTH-bit value.
  function automatic logic [64:0] ref_next(input int w, input logic [63:0] o, input logic c,
                                           input logic e, input logic [2:0] opc,
                                           input logic [63:0] wd, input logic s);
    logic [63:0] mask;
    logic [63:0] n;
    logic [63:0] msb;
    logic        nc;
    mask = (64'd1 << w) - 64'd1;
    msb  = (o >> (w - 1)) & 64'd1;
    n    = o;
    nc   = c;
    if (e) begin
      case (opc)
        3'd1: begin n = wd & mask; nc = 1'b0; end
        3'd2: begin n = 64'd0; nc = 1'b0; end
        3'd3: begin
          nc = (o == mask);
          if (c_SAT && o == mask) n = o;
          else n = (o + 64'd1) & mask;
        end
        3'd4: begin
          nc = (o == 64'd0);
          if (c_SAT && o == 64'd0) n = o;
          else n = (o - 64'd1) & mask;
        end
        3'd5: begin n = ((o << 1) | {63'd0, s}) & mask; nc = msb[0]; end
        3'd6: begin n = (o >> 1) | ({63'd0, s} << (w - 1)); nc = o[0]; end
        3'd7: begin n = ((o << 1) | msb) & mask; nc = msb[0]; end
        default: begin n = o; nc = c; end
      endcase
    end
    return {nc, n};
  endfunction

  task automatic model_reset();
    m_out_a = 64'h0;  m_car_a = 1'b0;
    m_out_b = 64'h3C; m_car_b = 1'b0;
    m_out_c = 64'h0;  m_car_c = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk_val({tag, ".a.out"},   {56'd0, out_a}, m_out_a);
    chk_val({tag, ".a.zero"},  {63'd0, zero_a}, {63'd0, (m_out_a == 64'd0)});
    chk_val({tag, ".a.carry"}, {63'd0, carry_a}, {63'd0, m_car_a});
    chk_val({tag, ".b.out"},   {56'd0, out_b}, m_out_b);
    chk_val({tag, ".b.zero"},  {63'd0, zero_b}, {63'd0, (m_out_b == 64'd0)});
    chk_val({tag, ".b.carry"}, {63'd0, carry_b}, {63'd0, m_car_b});
    chk_val({tag, ".c.out"},   {62'd0, out_c}, m_out_c);
    chk_val({tag, ".c.zero"},  {63'd0, zero_c}, {63'd0, (m_out_c == 64'd0)});
    chk_val({tag, ".c.carry"}, {63'd0, carry_c}, {63'd0, m_car_c});
  endtask

  // Called at a falling edge. Drives the inputs, lets one rising edge
  // happen, then checks at the next falling edge.
  task automatic step(input string tag, input logic e, input logic [2:0] o,
                      input logic [7:0] wd, input logic s);
    logic [64:0] r;
    en = e; op = o; wdata = wd; sin = s;
    @(posedge clk);
    r = ref_next(8, m_out_a, m_car_a, e, o, {56'd0, wd}, s); {m_car_a, m_out_a} = r;
    r = ref_next(8, m_out_b, m_car_b, e, o, {56'd0, wd}, s); {m_car_b, m_out_b} = r;
    r = ref_next(2, m_out_c, m_car_c, e, o, {56'd0, wd}, s); {m_car_c, m_out_c} = r;
    @(negedge clk);
    check_all(tag);
  endtask

  // Pulses reset low entirely between clock edges. Called at a falling edge.
  task automatic reset_pulse(input string tag);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rstn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b1;
    en    = 1'b0;
    op    = 3'd0;
    wdata = 8'd0;
    sin   = 1'b0;
    model_reset();

    // Reset for two cycles, then idle with en=0.
    #2 rstn = 1'b0;
    #1;
    check_all("rst_async");
    chk_val("rst_b_val", {56'd0, out_b}, 64'h3C);
    repeat (2) @(negedge clk);
    check_all("rst_hold");
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("idle", 1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
      chk_val("idle_out", {56'd0, out_a}, 64'h00);
      chk_val("idle_zero", {63'd0, zero_a}, 64'd1);
      chk_val("idle_carry", {63'd0, carry_a}, 64'd0);
    end

    // Load, load, then a disabled load.
    step("load55", 1'b1, 3'd1, 8'h55, 1'b0);
    chk_val("load55_out", {56'd0, out_a}, 64'h55);
    step("loadA5", 1'b1, 3'd1, 8'hA5, 1'b0);
    chk_val("loadA5_out", {56'd0, out_a}, 64'hA5);
    step("loadCC_dis", 1'b0, 3'd1, 8'hCC, 1'b0);
    chk_val("dis_out", {56'd0, out_a}, 64'hA5);
    chk_val("dis_zero", {63'd0, zero_a}, 64'd0);
    chk_val("dis_carry", {63'd0, carry_a}, 64'd0);

    // Increment past all-ones and decrement below zero.
    step("loadFF", 1'b1, 3'd1, 8'hFF, 1'b0);
    step("incFF", 1'b1, 3'd3, 8'h00, 1'b0);
    chk_val("incFF_out", {56'd0, out_a}, c_SAT ? 64'hFF : 64'h00);
    chk_val("incFF_zero", {63'd0, zero_a}, c_SAT ? 64'd0 : 64'd1);
    chk_val("incFF_carry", {63'd0, carry_a}, 64'd1);
    step("clr", 1'b1, 3'd2, 8'h00, 1'b0);
    step("dec00", 1'b1, 3'd4, 8'h00, 1'b0);
    chk_val("dec00_out", {56'd0, out_a}, c_SAT ? 64'h00 : 64'hFF);
    chk_val("dec00_carry", {63'd0, carry_a}, 64'd1);

    // Shifts and rotate.
    step("load80", 1'b1, 3'd1, 8'h80, 1'b0);
    step("shl", 1'b1, 3'd5, 8'h00, 1'b1);
    chk_val("shl_out", {56'd0, out_a}, 64'h01);
    chk_val("shl_carry", {63'd0, carry_a}, 64'd1);
    step("shr", 1'b1, 3'd6, 8'h00, 1'b1);
    chk_val("shr_out", {56'd0, out_a}, 64'h80);
    chk_val("shr_carry", {63'd0, carry_a}, 64'd1);
    step("rol", 1'b1, 3'd7, 8'h00, 1'b0);
    chk_val("rol_out", {56'd0, out_a}, 64'h01);
    chk_val("rol_carry", {63'd0, carry_a}, 64'd1);
    step("clr2", 1'b1, 3'd2, 8'h00, 1'b0);
    chk_val("clr_out", {56'd0, out_a}, 64'h00);
    chk_val("clr_zero", {63'd0, zero_a}, 64'd1);
    chk_val("clr_carry", {63'd0, carry_a}, 64'd0);

    // Asynchronous reset between edges, then increment from RST_VAL.
    step("load66", 1'b1, 3'd1, 8'h66, 1'b0);
    reset_pulse("midrst");
    chk_val("midrst_b_out", {56'd0, out_b}, 64'h3C);
    chk_val("midrst_b_carry", {63'd0, carry_b}, 64'd0);
    step("inc3C", 1'b1, 3'd3, 8'h00, 1'b0);
    chk_val("inc3C_out", {56'd0, out_b}, 64'h3D);

    // Randomized operations.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 299) == 0)
        reset_pulse("rnd_rst");
      else
        step("rnd", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
             8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
